// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8) helpers for the iterative AES-128 encryptor.
package aes_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned RK_W  = 128;
  localparam int unsigned KEY_W = RK_W * (NR + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 sits in the most-significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Entry 0x00 occupies the top byte, so entry i lives at offset (255-i)*8 = ~i*8.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TAB[{~x, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock over an externally expanded key.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out
);

  logic [1:0]   fsm, fsm_nxt;
  logic [3:0]   round, round_nxt;
  logic [127:0] state_reg, state_nxt;
  logic [127:0] out_nxt;
  logic         out_valid_nxt;

  logic [127:0] rk0, rk, sub, sr, mc;

  assign rk0      = key[RK_W-1:0];
  assign rk       = key[{round, 7'b0000000} +: RK_W];
  assign in_ready = (fsm == ST_IDLE);

  // SubBytes
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .x(state_reg[127-8*i -: 8]),
      .y(sub[127-8*i -: 8])
    );
  end

  // ShiftRows then MixColumns; byte n = row + 4*col.
  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] = sub[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end
  end

  always_comb begin
    fsm_nxt       = fsm;
    round_nxt     = round;
    state_nxt     = state_reg;
    out_nxt       = out;
    out_valid_nxt = out_valid;
    case (fsm)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt = in ^ rk0;
          round_nxt = 4'd1;
          fsm_nxt   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (round == 4'(NR)) begin
          state_nxt     = sr ^ rk;
          out_nxt       = sr ^ rk;
          out_valid_nxt = 1'b1;
          round_nxt     = 4'd0;
          fsm_nxt       = ST_DONE;
        end else begin
          state_nxt = mc ^ rk;
          round_nxt = round + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_nxt       = '0;
          out_valid_nxt = 1'b0;
          fsm_nxt       = ST_IDLE;
        end
      end
      default: begin
        fsm_nxt       = ST_IDLE;
        round_nxt     = 4'd0;
        out_nxt       = '0;
        out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= ST_IDLE;
      round     <= 4'd0;
      state_reg <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      fsm       <= fsm_nxt;
      round     <= round_nxt;
      state_reg <= state_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: known-answer vectors, random blocks
// against an AES-128 reference model, backpressure, busy input and mid-run reset.
module tb_aes_encrypt_iter;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [1407:0] key;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out;

  int vecs = 0;
  int errs = 0;
  logic [7:0] sbox_tab [256];

  always #5 clk = ~clk;

  aes_encrypt_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in_data),
    .key      (key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [1407:0] kext(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] kb;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    kb = '0;
    for (int r = 0; r < 11; r++) kb[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return kb;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [1407:0] kb);
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   v [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ kb[127-8*b -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          u[row+4*c] = sbox_tab[s[row+4*((c+row)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        if (r < 10) begin
          v[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          v[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          v[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          v[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          v[4*c] = a0; v[4*c+1] = a1; v[4*c+2] = a2; v[4*c+3] = a3;
        end
      end
      for (int b = 0; b < 16; b++) s[b] = v[b] ^ kb[128*r + 127 - 8*b -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block, wait for the result, apply backpressure, then complete the handshake.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [1407:0] kb,
                           input logic [127:0] exp, input int hold, input bit poke);
    int lat;
    key       = kb;
    in_data   = pt;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy_ready"}, 128'(in_ready), 128'(1'b0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = poke && lat >= 2 && lat <= 4;
      in_data  = rnd128();
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 128'(lat), 128'(10));
    chk({tag, "_out"}, out, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = poke;
      @(posedge clk); #1;
      if (i == hold - 1) begin
        chk({tag, "_hold_out"}, out, exp);
        chk({tag, "_hold_valid"}, 128'(out_valid), 128'(1'b1));
        chk({tag, "_hold_ready"}, 128'(in_ready), 128'(1'b0));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 128'(out_valid), 128'(1'b0));
    chk({tag, "_drain_ready"}, 128'(in_ready), 128'(1'b1));
    chk({tag, "_drain_out"}, out, 128'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0]  pt, k;
    logic [1407:0] kb_b;

    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    key       = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out", out, 128'h0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));

    kb_b = kext(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_block("fips_b", 128'h3243f6a8885a308d313198a2e0370734, kb_b,
              128'h3925841d02dc09fbdc118597196a0b32, 5, 1'b0);
    run_block("fips_c1", 128'h00112233445566778899aabbccddeeff,
              kext(128'h000102030405060708090a0b0c0d0e0f),
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 1'b0);
    run_block("vec3", 128'h0123456789abcdeffedcba9876543210,
              kext(128'h0f1571c947d9e8590cb7add6af7f6798),
              128'hff0b844a0853bf7c6934ab4364148fb9, 2, 1'b0);
    run_block("busy", 128'h3243f6a8885a308d313198a2e0370734, kb_b,
              128'h3925841d02dc09fbdc118597196a0b32, 3, 1'b1);

    for (int n = 0; n < 6; n++) begin
      pt = rnd128();
      k  = rnd128();
      run_block($sformatf("rnd%0d", n), pt, kext(k), ref_encrypt(pt, kext(k)),
                int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a run abandons the block.
    key      = kb_b;
    in_data  = 128'h3243f6a8885a308d313198a2e0370734;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #2;
    chk("midrst_valid", 128'(out_valid), 128'(1'b0));
    chk("midrst_ready", 128'(in_ready), 128'(1'b1));
    chk("midrst_out", out, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("postrst_valid", 128'(out_valid), 128'(1'b0));
    chk("postrst_ready", 128'(in_ready), 128'(1'b1));
    run_block("rerun_b", 128'h3243f6a8885a308d313198a2e0370734, kb_b,
              128'h3925841d02dc09fbdc118597196a0b32, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
